// File: rtl/am2302_pkg.sv
// Shared types and default timing for the AM2302 single-wire sensor model.
// All timing constants are in clk cycles at 36.927 MHz.
package am2302_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    localparam int DEF_T_START_MIN = 29542;
    localparam int DEF_T_WAIT      = 1108;
    localparam int DEF_T_RESP_LOW  = 2954;
    localparam int DEF_T_RESP_HIGH = 2954;
    localparam int DEF_T_BIT_LOW   = 1846;
    localparam int DEF_T_BIT0_HIGH = 960;
    localparam int DEF_T_BIT1_HIGH = 2585;

    localparam int FRAME_BITS = 40;

    // Byte-wise sum mod 256, as the sensor sends it in the fifth byte.
    function automatic logic [7:0] frame_checksum(input logic [15:0] h, input logic [15:0] t);
        return h[15:8] + h[7:0] + t[15:8] + t[7:0];
    endfunction

endpackage

// File: rtl/am2302_sda_sync.sv
// Two-flop synchronizer for the open-drain sda line, with rise/fall pulses.
// Anything that is not a clean 0 reads as 1, matching the bus pull-up.
module am2302_sda_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sda,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sda_clean;
    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_comb begin
        sda_clean = 1'b1;
        case (sda)
            1'b0:    sda_clean = 1'b0;
            default: sda_clean = 1'b1;
        endcase
    end

    // Flops reset to 1 so an idle bus never produces a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
        end else begin
            sync_1 <= sda_clean;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign level = sync_2;
    assign rise  = sync_2 & ~sync_3;
    assign fall  = ~sync_2 & sync_3;

endmodule

// File: rtl/am2302_sensor_model.sv
// AM2302 slave emulation: waits for a host start pulse on sda, then sends the
// response preamble and the 40-bit {hum, temp, checksum} frame, MSB first.
module am2302_sensor_model
    import am2302_pkg::*;
#(
    parameter int T_START_MIN = DEF_T_START_MIN,
    parameter int T_WAIT      = DEF_T_WAIT,
    parameter int T_RESP_LOW  = DEF_T_RESP_LOW,
    parameter int T_RESP_HIGH = DEF_T_RESP_HIGH,
    parameter int T_BIT_LOW   = DEF_T_BIT_LOW,
    parameter int T_BIT0_HIGH = DEF_T_BIT0_HIGH,
    parameter int T_BIT1_HIGH = DEF_T_BIT1_HIGH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] hum,
    input  logic [15:0] temp,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_cnt,
    inout  wire         sda
);

    // Each timed state lasts exactly T cycles: it exits when timer hits T-1.
    localparam logic [15:0] START_MIN      = 16'(T_START_MIN);
    localparam logic [15:0] WAIT_LAST      = 16'(T_WAIT - 1);
    localparam logic [15:0] RESP_LOW_LAST  = 16'(T_RESP_LOW - 1);
    localparam logic [15:0] RESP_HIGH_LAST = 16'(T_RESP_HIGH - 1);
    localparam logic [15:0] BIT_LOW_LAST   = 16'(T_BIT_LOW - 1);
    localparam logic [15:0] BIT0_LAST      = 16'(T_BIT0_HIGH - 1);
    localparam logic [15:0] BIT1_LAST      = 16'(T_BIT1_HIGH - 1);
    localparam logic [5:0]  LAST_BIT       = 6'(FRAME_BITS - 1);

    state_t                  state;
    logic [15:0]             timer;
    logic [FRAME_BITS-1:0]   shreg;
    logic [5:0]              bit_idx;
    logic                    drive_low;
    logic                    sda_level;
    logic                    sda_rise;
    logic                    sda_fall;
    logic [15:0]             bit_high_last;

    am2302_sda_sync u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sda   (sda),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Open drain: only ever pull low; drive_low clears asynchronously on reset.
    assign sda = drive_low ? 1'b0 : 1'bz;

    assign bit_high_last = shreg[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            // Registered from the current state, so every driven low starts
            // one clk after its state is entered and lasts the state's length.
            drive_low <= (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
            if (timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end

            case (state)
                IDLE: begin
                    // Level check also catches a host low already in progress.
                    if (en && (sda_fall || !sda_level)) begin
                        state <= HOST_LOW;
                        timer <= '0;
                    end
                end
                HOST_LOW: begin
                    if (sda_rise) begin
                        timer <= '0;
                        if (timer >= START_MIN) begin
                            shreg   <= {hum, temp, frame_checksum(hum, temp)};
                            bit_idx <= '0;
                            busy    <= 1'b1;
                            state   <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (timer == WAIT_LAST) begin
                        state <= RESP_LOW;
                        timer <= '0;
                    end
                end
                RESP_LOW: begin
                    if (timer == RESP_LOW_LAST) begin
                        state <= RESP_HIGH;
                        timer <= '0;
                    end
                end
                RESP_HIGH: begin
                    if (timer == RESP_HIGH_LAST) begin
                        state <= BIT_LOW;
                        timer <= '0;
                    end
                end
                BIT_LOW: begin
                    if (timer == BIT_LOW_LAST) begin
                        state <= BIT_HIGH;
                        timer <= '0;
                    end
                end
                BIT_HIGH: begin
                    if (timer == bit_high_last) begin
                        shreg   <= shreg << 1;
                        bit_idx <= bit_idx + 6'd1;
                        timer   <= '0;
                        state   <= (bit_idx == LAST_BIT) ? END_LOW : BIT_LOW;
                    end
                end
                END_LOW: begin
                    if (timer == BIT_LOW_LAST) begin
                        state     <= IDLE;
                        timer     <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am2302_sensor_model.sv
// Bench for am2302_sensor_model with shortened timing so full frames and the
// 256-frame counter wrap fit in a short run.
module tb_am2302_sensor_model;
    import am2302_pkg::*;

    localparam int TS  = 16;
    localparam int TW  = 3;
    localparam int TRL = 6;
    localparam int TRH = 5;
    localparam int TBL = 2;
    localparam int T0  = 1;
    localparam int T1  = 4;
    localparam int FRAME_BUDGET = TW + TRL + TRH + FRAME_BITS * (TBL + T1) + TBL + 20;
    localparam int HOST_OK = 24;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] hum;
    logic [15:0] temp;
    logic        busy;
    logic        done;
    logic [7:0]  frame_cnt;
    wire         sda;
    logic        host_low;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int exp_frames = 0;
    logic busy_seen = 1'b0;
    logic rec_en = 1'b0;
    logic prev_lvl = 1'b1;
    int fall_t[$];
    int rise_t[$];

    pullup (sda);
    assign sda = host_low ? 1'b0 : 1'bz;

    am2302_sensor_model #(
        .T_START_MIN (TS),
        .T_WAIT      (TW),
        .T_RESP_LOW  (TRL),
        .T_RESP_HIGH (TRH),
        .T_BIT_LOW   (TBL),
        .T_BIT0_HIGH (T0),
        .T_BIT1_HIGH (T1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hum       (hum),
        .temp      (temp),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt),
        .sda       (sda)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Line monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        logic cur;
        cur = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (rec_en) begin
            if (prev_lvl && !cur) fall_t.push_back(cyc);
            if (!prev_lvl && cur) rise_t.push_back(cyc);
        end
        prev_lvl = cur;
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    // ---------------- reference model ----------------
    function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t);
        int sum;
        sum = h / 256 + h % 256 + t / 256 + t % 256;
        return {h, t, 8'(sum % 256)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_pulse(input int len);
        host_low = 1'b1;
        repeat (len) tick();
        host_low = 1'b0;
        tick();
    endtask

    task automatic start_record();
        fall_t.delete();
        rise_t.delete();
        rec_en = 1'b1;
    endtask

    // Host start pulse, then record the line until done (bounded).
    task automatic run_request(input int host_len, input int budget, output int got_done);
        int d0;
        host_pulse(host_len);
        start_record();
        d0 = done_seen;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done_seen != d0) break;
        end
        repeat (4) tick();
        rec_en = 1'b0;
        got_done = done_seen - d0;
    endtask

    // Decode recorded edges and compare them with the model's frame and timing.
    task automatic check_frame(input logic [15:0] h, input logic [15:0] t, input string tag,
                               output logic [39:0] got_f);
        logic [39:0] exp_f;
        int per;
        int exp_per;
        exp_f = model_frame(h, t);
        got_f = '0;
        checks++;
        if (fall_t.size() != FRAME_BITS + 2 || rise_t.size() != FRAME_BITS + 2) begin
            errors++;
            $display("FAIL %s edge_count falls=%0d rises=%0d exp=%0d", tag,
                     fall_t.size(), rise_t.size(), FRAME_BITS + 2);
            return;
        end
        checks++;
        if (rise_t[0] - fall_t[0] != TRL) begin
            errors++;
            $display("FAIL %s resp_low got=%0d exp=%0d", tag, rise_t[0] - fall_t[0], TRL);
        end
        checks++;
        if (fall_t[1] - rise_t[0] != TRH) begin
            errors++;
            $display("FAIL %s resp_high got=%0d exp=%0d", tag, fall_t[1] - rise_t[0], TRH);
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            checks++;
            if (rise_t[i+1] - fall_t[i+1] != TBL) begin
                errors++;
                $display("FAIL %s bit%0d_low got=%0d exp=%0d", tag, i, rise_t[i+1] - fall_t[i+1], TBL);
            end
            per = fall_t[i+2] - fall_t[i+1];
            got_f[39-i] = (per > TBL + T0);
            exp_per = TBL + (exp_f[39-i] ? T1 : T0);
            checks++;
            if (per != exp_per) begin
                errors++;
                $display("FAIL %s bit%0d_period got=%0d exp=%0d", tag, i, per, exp_per);
            end
        end
        checks++;
        if (rise_t[41] - fall_t[41] != TBL) begin
            errors++;
            $display("FAIL %s end_low got=%0d exp=%0d", tag, rise_t[41] - fall_t[41], TBL);
        end
        checks++;
        if (got_f !== exp_f) begin
            errors++;
            $display("FAIL %s frame got=%h exp=%h", tag, got_f, exp_f);
        end
    endtask

    task automatic check_after_frame(input int got_done, input string tag);
        checks++;
        if (got_done != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d exp=1", tag, got_done);
        end
        checks++;
        if (frame_cnt !== 8'(exp_frames % 256)) begin
            errors++;
            $display("FAIL %s frame_cnt got=%0d exp=%0d", tag, frame_cnt, exp_frames % 256);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after got=%b exp=0", tag, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset outputs busy=%b done=%b frame_cnt=%0d exp 0/0/0", busy, done, frame_cnt);
        end
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL reset sda got=%b exp=1 (released)", sda);
        end
        checks++;
        if (dut.state !== IDLE || dut.timer !== 16'd0) begin
            errors++;
            $display("FAIL reset state=%0d timer=%0d exp IDLE/0", dut.state, dut.timer);
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic_frame();
        int gd;
        logic [39:0] got;
        hum = 16'h028C;
        temp = 16'h015F;
        run_request(HOST_OK + 10, FRAME_BUDGET, gd);
        exp_frames++;
        check_frame(hum, temp, "basic", got);
        checks++;
        if (got[7:0] !== 8'hEE) begin
            errors++;
            $display("FAIL basic checksum got=%h exp=ee", got[7:0]);
        end
        check_after_frame(gd, "basic");
    endtask

    task automatic test_glitch();
        int gd;
        busy_seen = 1'b0;
        run_request(10, 80, gd);
        checks++;
        if (fall_t.size() != 0 || gd != 0) begin
            errors++;
            $display("FAIL glitch response falls=%0d done=%0d exp 0/0", fall_t.size(), gd);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch busy got=1 exp=0");
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL glitch state got=%0d exp=IDLE", dut.state);
        end
    endtask

    // Inputs change and en drops while busy; the latched frame must still go out.
    task automatic test_hold_change();
        int d0;
        int gd;
        logic [15:0] h0;
        logic [15:0] t0;
        logic [39:0] got;
        h0 = 16'h8000;
        t0 = 16'h0000;
        hum = h0;
        temp = t0;
        host_pulse(HOST_OK);
        start_record();
        d0 = done_seen;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy === 1'b1) break;
        end
        hum = 16'h0000;
        temp = 16'($urandom_range(0, 65535));
        en = 1'b0;
        for (int k = 0; k < FRAME_BUDGET; k++) begin
            tick();
            if (done_seen != d0) break;
        end
        repeat (4) tick();
        rec_en = 1'b0;
        gd = done_seen - d0;
        exp_frames++;
        check_frame(h0, t0, "hold", got);
        check_after_frame(gd, "hold");
        en = 1'b1;
    endtask

    task automatic test_random();
        int gd;
        logic [39:0] got;
        for (int n = 0; n < 3; n++) begin
            hum = 16'($urandom_range(0, 65535));
            temp = 16'($urandom_range(0, 65535));
            run_request(HOST_OK + int'($urandom_range(0, 8)), FRAME_BUDGET, gd);
            exp_frames++;
            check_frame(hum, temp, "random", got);
            check_after_frame(gd, "random");
            repeat (int'($urandom_range(6, 12))) tick();
        end
    endtask

    // Host starts pulling low during END_LOW; the new start is timed from IDLE.
    task automatic test_back_to_back();
        int d0;
        int gd;
        logic [39:0] got;
        hum = 16'h1234;
        temp = 16'h8065;
        host_pulse(HOST_OK);
        start_record();
        d0 = done_seen;
        for (int k = 0; k < FRAME_BUDGET; k++) begin
            tick();
            if (fall_t.size() >= FRAME_BITS + 2) break;
        end
        rec_en = 1'b0;
        host_low = 1'b1;
        repeat (HOST_OK + 6) tick();
        exp_frames++;
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL b2b first_done got=%0d exp=1", done_seen - d0);
        end
        host_low = 1'b0;
        tick();
        start_record();
        d0 = done_seen;
        for (int k = 0; k < FRAME_BUDGET; k++) begin
            tick();
            if (done_seen != d0) break;
        end
        repeat (4) tick();
        rec_en = 1'b0;
        gd = done_seen - d0;
        exp_frames++;
        check_frame(hum, temp, "b2b", got);
        check_after_frame(gd, "b2b");
    endtask

    task automatic test_en_low();
        int gd;
        en = 1'b0;
        busy_seen = 1'b0;
        run_request(HOST_OK + 10, 100, gd);
        checks++;
        if (fall_t.size() != 0 || gd != 0 || busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL en_low response falls=%0d done=%0d busy=%b exp 0/0/0",
                     fall_t.size(), gd, busy_seen);
        end
        checks++;
        if (frame_cnt !== 8'(exp_frames % 256)) begin
            errors++;
            $display("FAIL en_low frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames % 256);
        end
        en = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int gd;
        logic [39:0] got;
        hum = 16'($urandom_range(0, 65535));
        temp = 16'($urandom_range(0, 65535));
        host_pulse(HOST_OK);
        start_record();
        // Falls: response, then bits 0..17; the 19th is the start of bit 17.
        for (int k = 0; k < FRAME_BUDGET; k++) begin
            tick();
            if (fall_t.size() >= 19) break;
        end
        rec_en = 1'b0;
        checks++;
        if (fall_t.size() != 19 || sda !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid reach_bit17 falls=%0d sda=%b exp 19/0", fall_t.size(), sda);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid sda_release got=%b exp=1", sda);
        end
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 8'd0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid cleared busy=%b frame_cnt=%0d state=%0d exp 0/0/IDLE",
                     busy, frame_cnt, dut.state);
        end
        exp_frames = 0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        run_request(37, FRAME_BUDGET, gd);
        exp_frames++;
        check_frame(hum, temp, "rst_mid_fresh", got);
        check_after_frame(gd, "rst_mid_fresh");
    endtask

    task automatic test_wrap();
        int gd;
        hum = 16'h0000;
        temp = 16'h0000;
        while (exp_frames < 256) begin
            run_request(HOST_OK, FRAME_BUDGET, gd);
            exp_frames++;
            check_after_frame(gd, "wrap");
            repeat (4) tick();
            if (gd != 1) break;
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap final frame_cnt got=%0d exp=0", frame_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        hum = '0;
        temp = '0;
        host_low = 1'b0;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_hold_change();
        test_random();
        test_back_to_back();
        test_en_low();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
